// File: rtl/cb_encode_19.sv
// CB-format branch encoder: two-stage valid/ready pipeline.
// S1 holds target-pc, op and rt; S2 holds the encoded word and error flags.
module cb_encode_19 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] pc,
  input  logic [63:0] target,
  input  logic [1:0]  op,
  input  logic [4:0]  rt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic        err_align,
  output logic        err_range,
  output logic        err_op,
  output logic [7:0]  err_count
);

  logic        r_s1_valid;
  logic [63:0] r_diff;
  logic [1:0]  r_op;
  logic [4:0]  r_rt;
  logic        r_out_valid;
  logic [31:0] r_instr;
  logic        r_ea, r_er, r_eo;
  logic [7:0]  r_err_cnt;

  logic        w_s2_load, w_s1_load;
  logic        w_ea, w_er, w_eo;
  logic [18:0] w_imm19;
  logic [31:0] w_instr;
  logic        w_deliver_err;

  assign w_s2_load = !r_out_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign in_ready  = w_s1_load;

  // Byte offset must fit in 21 signed bits: upper bits are pure sign extension.
  assign w_imm19 = r_diff[20:2];
  assign w_ea    = |r_diff[1:0];
  assign w_er    = !((&r_diff[63:20]) || (~|r_diff[63:20]));
  assign w_eo    = (r_op == 2'b11);

  always_comb begin
    w_instr = 32'h0;
    case (r_op)
      2'b00:   w_instr = {8'hB4, w_imm19, r_rt};
      2'b01:   w_instr = {8'hB5, w_imm19, r_rt};
      2'b10:   w_instr = {8'h54, w_imm19, 1'b0, r_rt[3:0]};
      default: w_instr = 32'h0;
    endcase
    if (w_ea || w_er || w_eo) w_instr = 32'h0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_diff     <= 64'h0;
      r_op       <= 2'b00;
      r_rt       <= 5'h0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_diff <= target - pc;
        r_op   <= op;
        r_rt   <= rt;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_instr     <= 32'h0;
      r_ea        <= 1'b0;
      r_er        <= 1'b0;
      r_eo        <= 1'b0;
    end else if (w_s2_load) begin
      r_out_valid <= r_s1_valid;
      r_instr     <= w_instr;
      r_ea        <= w_ea;
      r_er        <= w_er;
      r_eo        <= w_eo;
    end
  end

  assign w_deliver_err = r_out_valid && out_ready && (r_ea || r_er || r_eo);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              r_err_cnt <= 8'h00;
    else if (w_deliver_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'h01;
  end

  assign out_valid = r_out_valid;
  assign instr     = r_instr;
  assign err_align = r_ea;
  assign err_range = r_er;
  assign err_op    = r_eo;
  assign err_count = r_err_cnt;

endmodule

// File: tb/tb_cb_encode_19.sv
// Bench for cb_encode_19: queue-based reference model checked every cycle,
// plus literal expectations for the directed encodings and corner cases.
module tb_cb_encode_19;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] pc = 64'h0;
  logic [63:0] target = 64'h0;
  logic [1:0]  op = 2'b00;
  logic [4:0]  rt = 5'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] instr;
  logic        err_align, err_range, err_op;
  logic [7:0]  err_count;

  cb_encode_19 dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .target(target), .op(op), .rt(rt),
    .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
    .err_align(err_align), .err_range(err_range), .err_op(err_op),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        ea, er, eo;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   m_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Encoding derived from signed byte distance with plain arithmetic.
  function automatic exp_t model(input logic [63:0] p, input logic [63:0] t,
                                 input logic [1:0] o, input logic [4:0] r);
    exp_t e;
    longint d;
    longint sh;
    logic [63:0] imm;
    logic [63:0] w;
    d    = longint'(t - p);
    e.ea = (d % 4) != 0;
    e.er = (d < -64'sd1048576) || (d > 64'sd1048575);
    e.eo = (o == 2'd3);
    sh   = d >>> 2;
    imm  = 64'(sh) & 64'h7FFFF;
    case (o)
      2'd0:    w = (64'hB4 << 24) | (imm << 5) | 64'(r);
      2'd1:    w = (64'hB5 << 24) | (imm << 5) | 64'(r);
      2'd2:    w = (64'h54 << 24) | (imm << 5) | 64'(r % 16);
      default: w = 64'h0;
    endcase
    if (e.ea || e.er || e.eo) w = 64'h0;
    e.instr = w[31:0];
    e.acc   = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic exp_ov;
    if (!reset_n) begin
      q.delete();
      m_cnt = 0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_err_count", err_count, 0);
    end else begin
      exp_ov = 1'b0;
      if (q.size() > 0) exp_ov = (cyc >= q[0].acc + 2);
      chk("out_valid", out_valid, exp_ov);
      chk("in_ready", in_ready, (q.size() < 2) || out_ready);
      chk("err_count", err_count, m_cnt);
      if (out_valid && q.size() > 0) begin
        chk("instr", instr, q[0].instr);
        chk("flags", {err_align, err_range, err_op}, {q[0].ea, q[0].er, q[0].eo});
      end
      if (out_valid && out_ready && q.size() > 0) begin
        e = q.pop_front();
        if ((e.ea || e.er || e.eo) && m_cnt < 255) m_cnt++;
      end
      if (in_valid && in_ready) begin
        e = model(pc, target, op, rt);
        e.acc = cyc;
        q.push_back(e);
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [63:0] p, input logic [63:0] d,
                          input logic [1:0] o, input logic [4:0] r,
                          input logic [31:0] exp_i, input logic [2:0] exp_e,
                          input string nm);
    in_valid = 1'b1; pc = p; target = p + d; op = o; rt = r; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk({nm, "_ov"}, out_valid, 1);
    chk({nm, "_instr"}, instr, exp_i);
    chk({nm, "_err"}, {err_align, err_range, err_op}, exp_e);
  endtask

  logic [63:0] edges [6] = '{64'hFFFFC, 64'h100000, 64'hFFFF_FFFF_FFF0_0000,
                             64'hFFFF_FFFF_FFEF_FFFC, 64'hFFFFF, 64'h0};

  initial begin
    logic [20:0] x;
    logic [63:0] d;
    int k;
    int n;
    #1;
    chk("init_out_valid", out_valid, 0);
    chk("init_instr", instr, 0);
    chk("init_flags", {err_align, err_range, err_op}, 0);
    chk("init_err_count", err_count, 0);
    step(); step();
    reset_n = 1'b1;
    chk("post_rst_in_ready", in_ready, 1);

    send_one(64'h1000, 64'h10, 2'd0, 5'd3, 32'hB400_0083, 3'b000, "cbz_fwd");
    send_one(64'h2000, 64'hFFFF_FFFF_FFFF_FFFC, 2'd2, 5'b10001, 32'h54FF_FFE1, 3'b000, "bcond_back");
    send_one(64'h4000, 64'hFFFFC, 2'd1, 5'd0, 32'hB57F_FFE0, 3'b000, "range_max");
    send_one(64'h4000, 64'h100000, 2'd1, 5'd0, 32'h0, 3'b010, "range_over");
    send_one(64'h4000, 64'hFFFF_FFFF_FFF0_0000, 2'd1, 5'd0, 32'hB580_0000, 3'b000, "range_min");
    chk("cnt_after_range", err_count, 1);
    send_one(64'h4000, 64'h6, 2'd1, 5'd0, 32'h0, 3'b100, "misalign");
    send_one(64'h4000, 64'h8, 2'd3, 5'd0, 32'h0, 3'b001, "illegal_op");
    send_one(64'h4000, 64'h100002, 2'd3, 5'd0, 32'h0, 3'b111, "all_errs");
    step(); step();
    chk("cnt_after_errs", err_count, 4);

    // Backpressure: three back-to-back requests with the consumer stalled.
    out_ready = 1'b0; in_valid = 1'b1; op = 2'd0; pc = 64'h8000;
    target = pc + 64'h20; rt = 5'd1; step();
    target = pc + 64'h24; rt = 5'd2; step();
    target = pc + 64'h28; rt = 5'd4;
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_hold_ov", out_valid, 1);
    chk("bp_hold_a", instr, 32'hB400_0101);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_ov", out_valid, 1);
      chk("bp_hold_a", instr, 32'hB400_0101);
      chk("bp_in_ready_low", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("bp_b", instr, 32'hB400_0122);
    step();
    chk("bp_c", instr, 32'hB400_0144);
    step();
    chk("bp_empty", out_valid, 0);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      pc = {$urandom, $urandom};
      op = 2'($urandom % 4);
      rt = 5'($urandom);
      k  = $urandom % 6;
      case (k)
        0:       d = 64'(longint'($urandom_range(0, 4095)) - 2048) << 2;
        1:       d = edges[$urandom % 6];
        2:       d = 64'(longint'($urandom_range(0, 4095)) - 2048);
        3:       d = {$urandom, $urandom};
        default: begin x = 21'($urandom); d = {{43{x[20]}}, x[20:2], 2'b00}; end
      endcase
      target = pc + d;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 10) begin step(); n++; end
    chk("drain_empty", q.size(), 0);

    // Saturation: 300 errored results.
    in_valid = 1'b1; op = 2'd3; out_ready = 1'b1;
    for (int i = 0; i < 300; i++) step();
    in_valid = 1'b0;
    step(); step(); step(); step();
    chk("cnt_saturated", err_count, 8'hFF);

    // Reset mid-operation with both stages occupied.
    reset_n = 1'b0; step(); reset_n = 1'b1;
    in_valid = 1'b1; op = 2'd3;
    for (int i = 0; i < 5; i++) step();
    in_valid = 1'b0;
    step(); step(); step(); step();
    chk("cnt_five", err_count, 5);
    out_ready = 1'b0; in_valid = 1'b1; op = 2'd0; target = pc + 64'h40;
    n = 0;
    while (in_ready && n < 10) begin step(); n++; end
    chk("full_in_ready", in_ready, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_err_count", err_count, 0);
    step();
    reset_n = 1'b1;
    chk("release_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("no_stale", out_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
